// File: rtl/serial_read_arbiter.sv
// serial_read_arbiter
// Round-robin arbiter for two read requesters sharing one 16-entry
// combinational memory. The granted requester's byte is read once and then
// streamed out LSB first, one bit per cycle. Every output is a register.

module serial_read_arbiter #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       req,
    input  logic [3:0]       addr0,
    input  logic [3:0]       addr1,
    output logic [1:0]       gnt,
    output logic [1:0]       ack,
    output logic [3:0]       mem_addr,
    input  logic [NBITS-1:0] mem_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             ser_owner
);

    // Bit counter wide enough to index every bit of the byte (3 bits for 8).
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [NBITS-1:0] shreg_reg;
    logic [CW-1:0]    bitcnt_reg;
    logic             owner_reg;
    logic             last_served_reg;

    // Requester that would win if a grant were issued this cycle.
    logic             pick;
    logic [1:0]       pick_onehot;

    // Round-robin choice: on contention the requester not served last wins,
    // otherwise the single active requester wins.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) begin
            pick = ~last_served_reg;
        end else begin
            pick = req[1];
        end
        pick_onehot = pick ? 2'b10 : 2'b01;
    end

    // Transaction FSM: grant and latch the address, load the byte, then
    // stream it out. Reset aborts any transfer immediately without an ack.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_reg       <= IDLE;
            shreg_reg       <= '0;
            bitcnt_reg      <= '0;
            owner_reg       <= 1'b0;
            last_served_reg <= 1'b1;
            gnt             <= 2'b00;
            ack             <= 2'b00;
            mem_addr        <= 4'd0;
            ser_out         <= 1'b0;
            ser_valid       <= 1'b0;
            ser_last        <= 1'b0;
            ser_owner       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The cycle spent here after a transfer is also the ack
                    // cycle; serial outputs drop back to zero at its end.
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    ack       <= 2'b00;
                    if (|req) begin
                        owner_reg       <= pick;
                        last_served_reg <= pick;
                        gnt             <= pick_onehot;
                        mem_addr        <= pick ? addr1 : addr0;
                        state_reg       <= LOAD;
                    end else begin
                        gnt <= 2'b00;
                    end
                end

                LOAD: begin
                    // mem_addr was latched at the grant, so mem_data is the
                    // owner's byte; later addr changes are not looked at.
                    shreg_reg  <= mem_data;
                    bitcnt_reg <= '0;
                    state_reg  <= SHIFT;
                end

                SHIFT: begin
                    ser_out   <= shreg_reg[bitcnt_reg];
                    ser_valid <= 1'b1;
                    ser_owner <= owner_reg;
                    if (bitcnt_reg == LAST_BIT) begin
                        // Counter stops at the last bit instead of wrapping.
                        ser_last  <= 1'b1;
                        ack       <= owner_reg ? 2'b10 : 2'b01;
                        state_reg <= IDLE;
                    end else begin
                        ser_last   <= 1'b0;
                        bitcnt_reg <= bitcnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
